viterbi_core: RTL
=================

# viterbi_core

Hard-decision Viterbi decoder core for the rate-1/2, K=3 convolutional code (generators 7,5 octal). It sits directly downstream of the input buffer and takes one 16-bit packet of eight 2-bit symbols from the buffer's bit-pair outputs. It decodes the packet with add-compare-select (ACS) and traceback, presents an 8-bit decoded byte with its final path metric, and pulses `refresh` back to the buffer to request the next packet.

## Interface
- `PM_W`, 6: path-metric width in bits.
- `PM_INIT`, 16: initial metric loaded into unreachable states 1..3.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  buffer's `valid_out`; bit pairs are stable and hold a packet.
- `bit_pair_0` .. `bit_pair_7`  in  2 each  received symbols 0..7; bit[1]=c1 (g=111), bit[0]=c0 (g=101).
- `refresh`  out  1  one-cycle pulse requesting the next packet from the buffer.
- `valid_out`  out  1  one-cycle pulse; `decoded_out` and `error_metric` are valid.
- `decoded_out`  out  8  decoded bits; [7]=symbol 0 ... [0]=symbol 7.
- `error_metric`  out  PM_W  winning path metric (Hamming distance).
- `busy`  out  1  high in every state except IDLE.

## Operation
- Encoder model:
  - State s={s1,s0}, where s1 is the most recent input bit.
  - For input u: c1=u^s1^s0, c0=u^s0; next state = {u,s1}.
  - Start state is 0.
- Branch metric: Hamming distance of the received pair to the expected {c1,c0}, range 0..2.
- FSM states: IDLE, ACS, SELECT, TRACE, DONE.
- IDLE:
  - If `valid_in`=1: latch all 8 pairs; set pm[0]=0 and pm[1..3]=PM_INIT; step=0; go to ACS.
  - Otherwise stay in IDLE.
- ACS (8 cycles, one symbol per cycle, symbol index = step):
  - For each next state ns, the predecessors are ps={ns[0],x} with x in {0,1} and u=ns[1].
  - new pm[ns] = min over x of (pm[ps]+bm). On a tie, pick x=0.
  - Store decision bit x in survivor memory dec[step][ns].
  - After step 7, go to SELECT.
- SELECT (1 cycle):
  - tb_state = index of the minimum pm; ties go to the lowest index.
  - Register `error_metric`=pm[tb_state]; set step=7; go to TRACE.
- TRACE (8 cycles):
  - Decoded bit for symbol t = tb_state[1], written to `decoded_out`[7-t].
  - tb_state <= {tb_state[0], dec[t][tb_state]}.
  - Decrement t; after t=0, go to DONE.
- DONE (1 cycle):
  - `valid_out`=1 and `refresh`=1; `decoded_out` and `error_metric` are stable.
  - Next state is IDLE.
- Arithmetic: metrics are unsigned PM_W bits. The maximum is PM_INIT+16=32 at defaults, so there is no overflow and no normalization.
- `valid_in` is ignored outside IDLE. Input pairs are not re-sampled after the capture edge.

## Timing
- Capture at edge E0 (IDLE and `valid_in`=1).
- ACS at edges E1..E8, SELECT at E9, TRACE at E10..E17.
- DONE occupies the cycle after E17: `valid_out` and `refresh` are high for exactly that one cycle, 18 clocks after capture.
- The earliest next capture is the edge ending the IDLE cycle after DONE. The buffer has then updated its `valid_out` in response to `refresh`, so a stale packet is never re-captured.
- Back-to-back throughput: one packet per 19 cycles.
- `decoded_out` and `error_metric` hold their last values until the next SELECT/TRACE overwrite them.
- Reset values: `refresh`=0, `valid_out`=0, `decoded_out`=0, `error_metric`=0, `busy`=0; FSM in IDLE; metrics and survivor memory cleared.
- Reset in any state, including mid-ACS or mid-TRACE:
  - Return to IDLE on the next edge.
  - No `refresh` and no `valid_out` pulse for the aborted packet.
- `rst` and `valid_in` in the same cycle: reset wins and the packet is not captured.

## Test plan
- Clean codeword: 16'hE170 (message 8'hB0) -> one `valid_out` pulse 18 clocks after capture with `decoded_out`=8'hB0, `error_metric`=1'd0, and `refresh` in the same cycle.
- Single symbol error: 16'h6170 (pair 0 = 01) -> `decoded_out`=8'hB0, `error_metric`=1.
- All-zero packet: 16'h0000 -> `decoded_out`=8'h00, `error_metric`=0.
- `valid_in` held high across two packets (E170, then 0000 after `refresh`):
  - Exactly two `valid_out`/`refresh` pulses, 19 cycles apart.
  - Second result is 8'h00.
  - No capture while `busy`.
- `rst` asserted 5 cycles after capture:
  - All outputs return to reset values; no pulses occur.
  - A subsequent packet 16'hE170 decodes to 8'hB0 with normal latency.
- `rst` coincident with `valid_in` -> no capture, `busy` stays 0.

Source files
------------

// File: rtl/viterbi_core.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5) code.
// Decodes one 8-symbol packet per pass: capture, 8 ACS steps, select, 8 traceback steps.
module viterbi_core #(
  parameter int PM_W    = 6,
  parameter int PM_INIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [1:0]      bit_pair_0,
  input  logic [1:0]      bit_pair_1,
  input  logic [1:0]      bit_pair_2,
  input  logic [1:0]      bit_pair_3,
  input  logic [1:0]      bit_pair_4,
  input  logic [1:0]      bit_pair_5,
  input  logic [1:0]      bit_pair_6,
  input  logic [1:0]      bit_pair_7,
  output logic            refresh,
  output logic            valid_out,
  output logic [7:0]      decoded_out,
  output logic [PM_W-1:0] error_metric,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, ACS, SELECT, TRACE, DONE} state_t;

  state_t          state, state_next;
  logic [1:0]      pairs [8];
  logic [PM_W-1:0] pm [4];
  logic [3:0]      dec [8];
  logic [2:0]      step;
  logic [1:0]      tb_state;

  logic [1:0]      rx;
  logic [1:0]      ns_b;
  logic [PM_W-1:0] cand0, cand1;
  logic [PM_W-1:0] pm_next [4];
  logic [3:0]      dec_bits;
  logic [1:0]      best;

  // Hamming distance between a received pair and the encoder output for (ps, u).
  function automatic logic [1:0] branch_metric(input logic [1:0] r, input logic [1:0] ps,
                                               input logic u);
    logic [1:0] d;
    d = r ^ {u ^ ps[1] ^ ps[0], u ^ ps[0]};
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  // Predecessors of ns are {ns[0],x}; the strict compare makes ties pick x=0.
  always_comb begin
    rx       = pairs[step];
    ns_b     = '0;
    cand0    = '0;
    cand1    = '0;
    dec_bits = '0;
    for (int i = 0; i < 4; i++) pm_next[i] = '0;
    for (int ns = 0; ns < 4; ns++) begin
      ns_b  = 2'(ns);
      cand0 = pm[{ns_b[0], 1'b0}] + PM_W'(branch_metric(rx, {ns_b[0], 1'b0}, ns_b[1]));
      cand1 = pm[{ns_b[0], 1'b1}] + PM_W'(branch_metric(rx, {ns_b[0], 1'b1}, ns_b[1]));
      if (cand1 < cand0) begin
        pm_next[ns]  = cand1;
        dec_bits[ns] = 1'b1;
      end else begin
        pm_next[ns] = cand0;
      end
    end
  end

  always_comb begin
    best = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (pm[i] < pm[best]) best = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid_in) state_next = ACS;
      ACS:     if (step == 3'd7) state_next = SELECT;
      SELECT:  state_next = TRACE;
      TRACE:   if (step == 3'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        pairs[i] <= '0;
        dec[i]   <= '0;
      end
      for (int i = 0; i < 4; i++) pm[i] <= '0;
      step         <= '0;
      tb_state     <= '0;
      decoded_out  <= '0;
      error_metric <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            pairs[0] <= bit_pair_0;
            pairs[1] <= bit_pair_1;
            pairs[2] <= bit_pair_2;
            pairs[3] <= bit_pair_3;
            pairs[4] <= bit_pair_4;
            pairs[5] <= bit_pair_5;
            pairs[6] <= bit_pair_6;
            pairs[7] <= bit_pair_7;
            pm[0]    <= '0;
            pm[1]    <= PM_W'(PM_INIT);
            pm[2]    <= PM_W'(PM_INIT);
            pm[3]    <= PM_W'(PM_INIT);
            step     <= '0;
          end
        end
        ACS: begin
          for (int i = 0; i < 4; i++) pm[i] <= pm_next[i];
          dec[step] <= dec_bits;
          step      <= step + 3'd1;
        end
        SELECT: begin
          tb_state     <= best;
          error_metric <= pm[best];
          step         <= 3'd7;
        end
        TRACE: begin
          // The newest input bit of the surviving state is the decoded bit for this symbol.
          decoded_out[3'd7 - step] <= tb_state[1];
          tb_state                 <= {tb_state[0], dec[step][tb_state]};
          step                     <= step - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign valid_out = (state == DONE);
  assign refresh   = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
